// File: rtl/fft_r2_dit_stage.sv
// rtl/fft_r2_dit_stage.sv - radix-2 DIT butterfly stage: fill A half, butterfly on B half, drain Y half
module fft_r2_dit_stage #(
    parameter int K     = 10,
    parameter int STAGE = 0,
    parameter int DW    = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          ready_o,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    input  logic          ready_i,
    output logic [K-2:0]  tw_idx_o,
    input  logic [DW-1:0] tw_i
);
    localparam int L  = 1 << STAGE;
    localparam int JW = (STAGE > 0) ? STAGE : 1;

    typedef enum logic [1:0] {FILL, BFLY, DRAIN} state_t;

    state_t        state_q;
    logic [JW-1:0] j_q;
    logic          valid_q;
    logic [DW-1:0] data_q;
    logic [DW-1:0] mem_q [L];

    logic          accept;
    logic          out_free;
    logic          last_j;
    logic          load;
    logic          advance;
    logic          mem_we;
    logic [DW-1:0] mem_wd;
    logic [DW-1:0] a_w;
    logic [DW-1:0] x_w;
    logic [DW-1:0] y_w;

    logic signed [15:0] ar, ai, br, bi, wr, wi;
    logic signed [32:0] pr, pi;
    logic signed [17:0] tr, ti;

    // (a +/- t) / 2 with floor, then clamp to the Q1.15 range
    function automatic logic [15:0] half_sat(input logic signed [15:0] a,
                                             input logic signed [17:0] t,
                                             input logic               sub);
        logic signed [18:0] s;
        s = sub ? (19'(a) - 19'(t)) : (19'(a) + 19'(t));
        s = s >>> 1;
        if (s > 19'sd32767) begin
            return 16'h7FFF;
        end
        if (s < -19'sd32768) begin
            return 16'h8000;
        end
        return s[15:0];
    endfunction

    always_comb begin
        a_w = mem_q[j_q];
        ar  = a_w[31:16];
        ai  = a_w[15:0];
        br  = data_i[31:16];
        bi  = data_i[15:0];
        wr  = tw_i[31:16];
        wi  = tw_i[15:0];
        pr  = 33'(br) * 33'(wr) - 33'(bi) * 33'(wi);
        pi  = 33'(br) * 33'(wi) + 33'(bi) * 33'(wr);
        tr  = 18'(pr >>> 15);
        ti  = 18'(pi >>> 15);
        x_w = {half_sat(ar, tr, 1'b0), half_sat(ai, ti, 1'b0)};
        y_w = {half_sat(ar, tr, 1'b1), half_sat(ai, ti, 1'b1)};
    end

    always_comb begin
        out_free = !valid_q || ready_i;
        unique case (state_q)
            FILL:    ready_o = 1'b1;
            BFLY:    ready_o = out_free;
            default: ready_o = 1'b0;
        endcase
        accept  = valid_i && ready_o;
        last_j  = (j_q == JW'(L - 1));
        load    = ((state_q == BFLY) && accept) || ((state_q == DRAIN) && out_free);
        advance = ((state_q != DRAIN) && accept) || ((state_q == DRAIN) && out_free);
        mem_we  = accept;
        mem_wd  = (state_q == FILL) ? data_i : y_w;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FILL;
            j_q     <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            // a new load always wins over a simultaneous pop
            if (load) begin
                valid_q <= 1'b1;
                data_q  <= (state_q == BFLY) ? x_w : a_w;
            end else if (ready_i) begin
                valid_q <= 1'b0;
            end
            if (advance) begin
                if (last_j) begin
                    j_q <= '0;
                    unique case (state_q)
                        FILL:    state_q <= BFLY;
                        BFLY:    state_q <= DRAIN;
                        default: state_q <= FILL;
                    endcase
                end else begin
                    j_q <= j_q + JW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[j_q] <= mem_wd;
        end
    end

    assign valid_o  = valid_q;
    assign data_o   = data_q;
    assign tw_idx_o = (K-1)'(j_q) << (K - 1 - STAGE);

endmodule
